// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM handshake state, data word, arbiter FSM state.
// Pure declarations, no latency.
// No flow control; consumers define their own handshakes.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: lowest-distance requester after `last`, wrapping modulo N.
// Purely combinational, zero latency.
// No backpressure; valid is low when no request is raised.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        int c;
        c     = 0;
        valid = 1'b0;
        idx   = '0;
        // Walk from farthest to nearest so the nearest raised request wins.
        for (int k = N; k >= 1; k--) begin
            c = (int'(last) + k) % N;
            if (req[c]) begin
                valid = 1'b1;
                idx   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for NCORES x (icache, dcache); dcache beats icache, RR within class.
// Request-to-data 2 cycles minimum (arbitrate in IDLE, data in GRANT on ACCESS); ARB_STATS_EN adds grant counters.
// Requesters stall on wait=1 until ramstate==ACCESS; ERROR re-arbitrates, a dropped request abandons the grant.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NCORES = 2
) (
    input  logic              CLK,
    input  logic              n_rst,
    input  logic [NCORES-1:0] iREN,
    input  word_t             iaddr      [NCORES],
    output logic [NCORES-1:0] iwait,
    output word_t             iload      [NCORES],
    input  logic [NCORES-1:0] dREN,
    input  logic [NCORES-1:0] dWEN,
    input  word_t             daddr      [NCORES],
    input  word_t             dstore     [NCORES],
    output logic [NCORES-1:0] dwait,
    output word_t             dload      [NCORES],
    output logic              ramREN,
    output logic              ramWEN,
    output word_t             ramaddr,
    output word_t             ramstore,
    input  word_t             ramload,
`ifdef ARB_STATS_EN
    output word_t             igrant_cnt [NCORES],
    output word_t             dgrant_cnt [NCORES],
`endif
    input  ramstate_t         ramstate
);

    localparam int CW = (NCORES > 1) ? $clog2(NCORES) : 1;

    arb_state_t        state;
    logic [CW-1:0]     g_core;
    logic              g_isd;
    logic              g_wr;
    logic [CW-1:0]     d_last;
    logic [CW-1:0]     i_last;

    logic [NCORES-1:0] dreq;
    logic              d_vld;
    logic              i_vld;
    logic [CW-1:0]     d_idx;
    logic [CW-1:0]     i_idx;
    logic              live;
    logic              done;

    assign dreq = dREN | dWEN;

    rr_pick #(.N(NCORES), .IW(CW)) u_dpick (
        .req   (dreq),
        .last  (d_last),
        .valid (d_vld),
        .idx   (d_idx)
    );

    rr_pick #(.N(NCORES), .IW(CW)) u_ipick (
        .req   (iREN),
        .last  (i_last),
        .valid (i_vld),
        .idx   (i_idx)
    );

    // A latched write whose dWEN falls counts as dropped; a read may upgrade to a write.
    always_comb begin
        live = 1'b0;
        if (state == GRANT) begin
            if (g_isd)
                live = g_wr ? dWEN[g_core] : dreq[g_core];
            else
                live = iREN[g_core];
        end
    end

    assign done = live && (ramstate == ACCESS);

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        for (int k = 0; k < NCORES; k++) begin
            iload[k] = '0;
            dload[k] = '0;
        end
        if (live) begin
            if (g_isd) begin
                ramWEN   = dWEN[g_core];
                ramREN   = dREN[g_core] & ~dWEN[g_core];
                ramaddr  = daddr[g_core];
                ramstore = dstore[g_core];
            end else begin
                ramREN   = 1'b1;
                ramaddr  = iaddr[g_core];
            end
        end
        if (done) begin
            if (g_isd) begin
                dwait[g_core] = 1'b0;
                dload[g_core] = ramload;
            end else begin
                iwait[g_core] = 1'b0;
                iload[g_core] = ramload;
            end
        end
    end

    // Pointers hold the last granted core; resetting them to NCORES-1 makes core 0 first.
    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            g_core <= '0;
            g_isd  <= 1'b0;
            g_wr   <= 1'b0;
            d_last <= CW'(NCORES - 1);
            i_last <= CW'(NCORES - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (d_vld) begin
                        g_core <= d_idx;
                        g_isd  <= 1'b1;
                        g_wr   <= dWEN[d_idx];
                        state  <= GRANT;
                    end else if (i_vld) begin
                        g_core <= i_idx;
                        g_isd  <= 1'b0;
                        g_wr   <= 1'b0;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (!live || ramstate == ERROR) begin
                        state <= IDLE;
                    end else if (ramstate == ACCESS) begin
                        state <= IDLE;
                        if (g_isd)
                            d_last <= g_core;
                        else
                            i_last <= g_core;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < NCORES; k++) begin
                igrant_cnt[k] <= '0;
                dgrant_cnt[k] <= '0;
            end
        end else if (done) begin
            for (int k = 0; k < NCORES; k++) begin
                if (g_core == CW'(k)) begin
                    if (g_isd)
                        dgrant_cnt[k] <= dgrant_cnt[k] + 32'd1;
                    else
                        igrant_cnt[k] <= igrant_cnt[k] + 32'd1;
                end
            end
        end
    end
`endif

endmodule
